program_loader: RTL and testbench



---
 rtl/program_loader.sv | 168 ++++++++++++++++
 tb/tb_program_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: byte-stream loader that fills the MC14500B instruction ROM.
// Latency: LO byte accepted at edge k -> one-cycle ROM write strobe in cycle k..k+1; FIN follows the last word.
// Backpressure: in_ready drops only in WR and FIN; otherwise the loader waits indefinitely for in_valid.
//
// Ports:
//   clk, rst                    single rising-edge clock, synchronous active-high reset
//   in_data/in_valid/in_ready   framed byte stream (START, LEN, {HI, LO} x count [, CSUM])
//   program_write/cmd/addr      ROM write port; cmd/addr hold their last values outside WR
//   core_rst                    holds the core in reset until a load completes successfully
//   busy, done, error           frame in progress, one-cycle success pulse, sticky error
//
// Optional feature: define PROGRAM_LOADER_CHECKSUM_EN to expect a trailing XOR checksum
// byte (covering LEN and every HI/LO byte) after the last word.

module program_loader #(
  parameter int         ADDR  = 8,
  parameter int         CODE  = 4,
  parameter int         WORD  = ADDR + CODE,
  parameter logic [7:0] START = 8'hA5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            program_write,
  output logic [WORD-1:0] program_cmd,
  output logic [ADDR-1:0] program_addr,
  output logic            core_rst,
  output logic            busy,
  output logic            done,
  output logic            error
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_HI   = 3'd2;
  localparam logic [2:0] S_LO   = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM = 3'd5;
`endif
  localparam logic [2:0] S_FIN  = 3'd6;

  // Largest legal word count (2^ADDR), kept 9 bits wide so it also covers ADDR=8.
  localparam logic [8:0] FULL_CNT = 9'd1 << ADDR;

  logic [2:0]      state;
  logic [8:0]      word_cnt;   // number of words in this frame, 1..2^ADDR
  logic [ADDR:0]   word_idx;   // one spare bit so the 2^ADDR-th increment is distinguishable
  logic [WORD-9:0] hi_byte;    // only the HI bits that land in the instruction
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  logic            accept;
  logic [8:0]      len_cnt;
  logic            len_oversize;
  logic [ADDR:0]   idx_nxt;
  logic            last_word;

  assign accept        = in_valid && in_ready;
  assign in_ready      = (state != S_WR) && (state != S_FIN);
  assign program_write = (state == S_WR);
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_FIN);

  // LEN==0 encodes a full ROM.
  assign len_cnt      = (in_data == 8'd0) ? FULL_CNT : {1'b0, in_data};
  assign len_oversize = (len_cnt > FULL_CNT);
  assign idx_nxt      = word_idx + {{ADDR{1'b0}}, 1'b1};
  assign last_word    = (9'(idx_nxt) == word_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      word_cnt     <= '0;
      word_idx     <= '0;
      hi_byte      <= '0;
      program_cmd  <= '0;
      program_addr <= '0;
      core_rst     <= 1'b1;
      error        <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && (in_data == START)) begin
            state    <= S_LEN;
            core_rst <= 1'b1;
            error    <= 1'b0;
          end
        end
        S_LEN: begin
          if (accept) begin
            if (len_oversize) begin
              // Reject the whole frame before any write; core stays in reset.
              error <= 1'b1;
              state <= S_IDLE;
            end else begin
              word_cnt <= len_cnt;
              word_idx <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              csum     <= in_data;
`endif
              state    <= S_HI;
            end
          end
        end
        S_HI: begin
          if (accept) begin
            hi_byte <= in_data[WORD-9:0];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum    <= csum ^ in_data;
`endif
            state   <= S_LO;
          end
        end
        S_LO: begin
          if (accept) begin
            // Latch the write port here so cmd/addr are stable for the whole WR cycle.
            program_cmd  <= {hi_byte, in_data};
            program_addr <= word_idx[ADDR-1:0];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum         <= csum ^ in_data;
`endif
            state        <= S_WR;
          end
        end
        S_WR: begin
          word_idx <= idx_nxt;
          if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state    <= S_CSUM;
`else
            state    <= S_FIN;
            core_rst <= 1'b0;
`endif
          end else begin
            state <= S_HI;
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            if (in_data == csum) begin
              state    <= S_FIN;
              core_rst <= 1'b0;
            end else begin
              error <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
`endif
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed bench for program_loader (ADDR=8 and ADDR=4 instances).
// Latency: each check is sampled #1 after a rising edge or from a negedge monitor.
// Backpressure: byte sends wait (bounded) for in_ready of both instances.

module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;

  logic        in_ready, program_write, core_rst, busy, done, error;
  logic [11:0] program_cmd;
  logic [7:0]  program_addr;

  logic        in_ready2, program_write2, core_rst2, busy2, done2, error2;
  logic [11:0] program_cmd2;
  logic [3:0]  program_addr2;

  int vectors = 0;
  int miscompares = 0;

  int          wr_cnt = 0;
  logic [7:0]  wr_addr [8];
  logic [11:0] wr_cmd  [8];
  int          done_cnt = 0;
  int          wr2_cnt = 0;
  logic [3:0]  wr2_last_addr = '0;
  logic [11:0] wr2_last_cmd = '0;
  int          done2_cnt = 0;

  program_loader #(.ADDR(8), .CODE(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .program_write(program_write), .program_cmd(program_cmd), .program_addr(program_addr),
    .core_rst(core_rst), .busy(busy), .done(done), .error(error)
  );

  program_loader #(.ADDR(4), .CODE(8)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
    .program_write(program_write2), .program_cmd(program_cmd2), .program_addr(program_addr2),
    .core_rst(core_rst2), .busy(busy2), .done(done2), .error(error2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (program_write) begin
      if (wr_cnt < 8) begin
        wr_addr[wr_cnt] = program_addr;
        wr_cmd[wr_cnt]  = program_cmd;
      end
      wr_cnt++;
    end
    if (done) done_cnt++;
    if (program_write2) begin
      wr2_last_addr = program_addr2;
      wr2_last_cmd  = program_cmd2;
      wr2_cnt++;
    end
    if (done2) done2_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!(in_ready && in_ready2) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready_wait", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic clear_mon();
    wr_cnt = 0; done_cnt = 0; wr2_cnt = 0; done2_cnt = 0;
  endtask

  initial begin
    // Reset values
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_core_rst", core_rst, 1);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_write", program_write, 0);
    check("rst_error", error, 0);
    check("rst_done", done, 0);
    check("rst_cmd", program_cmd, 0);
    check("rst_addr", program_addr, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    clear_mon();

    // Junk before a frame is discarded
    send(8'h00);
    check("junk_ready", in_ready, 1);
    send(8'h55);
    check("junk_busy", busy, 0);
    check("junk_writes", wr_cnt, 0);

    // Valid two-word frame
    send(8'hA5);
    check("start_busy", busy, 1);
    check("start_core_rst", core_rst, 1);
    send(8'h02); send(8'h01); send(8'h23);
    check("wr0_strobe", program_write, 1);
    check("wr0_in_ready", in_ready, 0);
    check("wr0_cmd", program_cmd, 12'h123);
    check("wr0_addr", program_addr, 0);
    send(8'h0F); send(8'hFF);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(8'hD0);
    check("fin_done", done, 1);
    check("fin_core_rst", core_rst, 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("ok_writes", wr_cnt, 2);
    check("ok_addr0", wr_addr[0], 0);
    check("ok_cmd0", wr_cmd[0], 12'h123);
    check("ok_addr1", wr_addr[1], 1);
    check("ok_cmd1", wr_cmd[1], 12'hFFF);
    check("ok_done_cnt", done_cnt, 1);
    check("ok_core_rst", core_rst, 0);
    check("ok_error", error, 0);
    check("ok_busy", busy, 0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Same frame, wrong checksum
    clear_mon();
    send(8'hA5); send(8'h02); send(8'h01); send(8'h23); send(8'h0F); send(8'hFF); send(8'hD1);
    repeat (3) @(posedge clk);
    #1;
    check("bad_writes", wr_cnt, 2);
    check("bad_error", error, 1);
    check("bad_core_rst", core_rst, 1);
    check("bad_done_cnt", done_cnt, 0);
    check("bad_busy", busy, 0);
`endif

    // Reset one cycle after the first write
    clear_mon();
    send(8'hA5); send(8'h02); send(8'h01); send(8'h23);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_busy", busy, 0);
    check("mid_core_rst", core_rst, 1);
    check("mid_cmd", program_cmd, 0);
    check("mid_error", error, 0);
    repeat (5) @(posedge clk);
    #1;
    check("mid_writes", wr_cnt, 1);
    clear_mon();
    send(8'hA5); send(8'h02); send(8'h01); send(8'h23); send(8'h0F); send(8'hFF);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(8'hD0);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reload_writes", wr_cnt, 2);
    check("reload_cmd0", wr_cmd[0], 12'h123);
    check("reload_cmd1", wr_cmd[1], 12'hFFF);
    check("reload_addr1", wr_addr[1], 1);
    check("reload_done_cnt", done_cnt, 1);
    check("reload_core_rst", core_rst, 0);

    // Single-word frame A5,01,03,45 (checksum 01^03^45 = 47 when enabled)
    clear_mon();
    send(8'hA5);
    check("one_core_rst_start", core_rst, 1);
    send(8'h01); send(8'h03); send(8'h45);
    check("one_cmd", program_cmd, 12'h345);
    check("one_addr", program_addr, 0);
    check("one_strobe", program_write, 1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(8'h47);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("one_writes", wr_cnt, 1);
    check("one_done_cnt", done_cnt, 1);
    check("one_core_rst", core_rst, 0);
    check("one_error", error, 0);

    // ADDR=4 instance: LEN=20 exceeds 16 words
    do_reset();
    clear_mon();
    send(8'hA5); send(8'h14);
    check("over_error", error2, 1);
    check("over_busy", busy2, 0);
    check("over_core_rst", core_rst2, 1);
    repeat (3) @(posedge clk);
    #1;
    check("over_writes", wr2_cnt, 0);

    // ADDR=4 instance: LEN=0 means 16 words; last write lands at address F
    do_reset();
    clear_mon();
    send(8'hA5);
    check("full_error_cleared", error2, 0);
    send(8'h00);
    for (int i = 0; i < 16; i++) begin
      send(8'(i));
      send(8'(8'h10 + i));
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("full_writes", wr2_cnt, 16);
    check("full_last_addr", wr2_last_addr, 4'hF);
    check("full_last_cmd", wr2_last_cmd, 12'hF1F);
    check("full_done_cnt", done2_cnt, 1);
    check("full_core_rst", core_rst2, 0);
    check("full_busy", busy2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
